icache_req_ctrl: RTL and testbench

//  Sequences instruction-fetch requests from pre-IF onto the icache request/response channel.

---
 rtl/icache_req_ctrl_pkg.sv | 14 +
 rtl/icache_req_ctrl_inst_req_fifo.sv | 65 ++++++
 rtl/icache_req_ctrl.sv | 133 +++++++++++++
 tb/tb_icache_req_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_req_ctrl_pkg.sv
// rtl/icache_req_ctrl_pkg.sv - shared types and defaults for the icache request controller
package icache_req_ctrl_pkg;

  // Default number of icache requests allowed in flight
  localparam int ICACHE_MAX_OUTST = 2;

  // IDLE: nothing in flight; BUSY: live requests in flight; DRAIN: stale responses pending
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } ireq_state_t;

endpackage

// File: rtl/icache_req_ctrl_inst_req_fifo.sv
// rtl/icache_req_ctrl_inst_req_fifo.sv - PC FIFO pairing outstanding fetches with their addresses
module inst_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Push/pop qualification, pointer wrap and occupancy update
  always_comb begin
    // A pop frees the head slot in the same cycle, so push while full is fine if popping
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/icache_req_ctrl.sv
// rtl/icache_req_ctrl.sv - icache fetch request sequencer with flush discard (opt: ICACHE_REQ_PERF_EN)
module icache_req_ctrl
  import icache_req_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = ICACHE_MAX_OUTST,
  parameter int ADDR_W    = 32,
  localparam int CW       = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              icache_req,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_addr_ok,
  input  logic              icache_data_ok,
  input  logic [31:0]       icache_rdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_inst,
  output logic [ADDR_W-1:0] resp_pc,
  output logic              data_cancel,
`ifdef ICACHE_REQ_PERF_EN
  output logic [31:0]       perf_req_cnt,
  output logic [31:0]       perf_cancel_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic [CW-1:0]     outst_cnt
);

  ireq_state_t   state_q, state_d;
  logic [CW-1:0] outst_cnt_q, outst_cnt_d;
  logic [CW-1:0] cancel_cnt_q, cancel_cnt_d;
  logic          full, accept;
  logic          fifo_full, fifo_empty;

  inst_req_fifo #(.DEPTH(MAX_OUTST), .W(ADDR_W)) u_pc_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (req_pc),
    .pop       (icache_data_ok),
    .head      (resp_pc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign icache_addr = req_pc;
  assign resp_inst   = icache_rdata;
  assign outst_cnt   = outst_cnt_q;

  // Output decode: issue gating on current count, discard of stale returns
  always_comb begin
    full        = (outst_cnt_q == CW'(MAX_OUTST));
    icache_req  = req_valid && !full && !flush;
    req_ready   = icache_addr_ok && !full && !flush;
    accept      = icache_req && icache_addr_ok;
    data_cancel = icache_data_ok && ((cancel_cnt_q != '0) || flush);
    resp_valid  = icache_data_ok && !data_cancel;
  end

  // Next-state: in-flight count, stale-response count and FSM state
  always_comb begin
    outst_cnt_d  = outst_cnt_q + CW'(accept) - CW'(icache_data_ok);
    cancel_cnt_d = cancel_cnt_q;
    if (flush) begin
      // Everything still in flight after this cycle's pop is now stale
      cancel_cnt_d = outst_cnt_d;
    end else if (data_cancel && (cancel_cnt_q != '0)) begin
      cancel_cnt_d = cancel_cnt_q - 1'b1;
    end
    if (cancel_cnt_d != '0)      state_d = DRAIN;
    else if (outst_cnt_d != '0)  state_d = BUSY;
    else                         state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      outst_cnt_q  <= '0;
      cancel_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      outst_cnt_q  <= outst_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  // Protocol checks: no return without a request in flight; FIFO mirrors the counter
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (icache_data_ok) assert (!fifo_empty && (outst_cnt_q != '0));
      assert (fifo_full == full);
      assert (cancel_cnt_q <= outst_cnt_q);
    end
  end

`ifdef ICACHE_REQ_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_cancel_q, perf_cancel_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_req_cnt    = perf_req_q;
  assign perf_cancel_cnt = perf_cancel_q;
  assign perf_stall_cnt  = perf_stall_q;

  // Saturating event counters
  always_comb begin
    perf_req_d    = perf_req_q;
    perf_cancel_d = perf_cancel_q;
    perf_stall_d  = perf_stall_q;
    if (accept && (perf_req_q != '1))                     perf_req_d    = perf_req_q + 1'b1;
    if (data_cancel && (perf_cancel_q != '1))             perf_cancel_d = perf_cancel_q + 1'b1;
    if (req_valid && !req_ready && (perf_stall_q != '1))  perf_stall_d  = perf_stall_q + 1'b1;
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_req_q    <= '0;
      perf_cancel_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_req_q    <= perf_req_d;
      perf_cancel_q <= perf_cancel_d;
      perf_stall_q  <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_icache_req_ctrl.sv
// tb/tb_icache_req_ctrl.sv - directed self-checking bench for icache_req_ctrl
module tb_icache_req_ctrl;
  import icache_req_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_ok;
  logic [31:0] icache_rdata;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] resp_pc;
  logic        data_cancel;
  logic [1:0]  outst_cnt;
`ifdef ICACHE_REQ_PERF_EN
  logic [31:0] perf_req_cnt, perf_cancel_cnt, perf_stall_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  icache_req_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .req_ready      (req_ready),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_addr_ok (icache_addr_ok),
    .icache_data_ok (icache_data_ok),
    .icache_rdata   (icache_rdata),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_inst      (resp_inst),
    .resp_pc        (resp_pc),
    .data_cancel    (data_cancel),
`ifdef ICACHE_REQ_PERF_EN
    .perf_req_cnt    (perf_req_cnt),
    .perf_cancel_cnt (perf_cancel_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .outst_cnt      (outst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid      = 1'b0;
    req_pc         = 32'h0;
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b0;
    icache_rdata   = 32'h0;
    flush          = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc);
    req_valid = 1'b1; req_pc = pc; icache_addr_ok = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b1; req_pc = 32'h100; icache_addr_ok = 1'b1;
    step();
    n_total++; if (outst_cnt !== 2'd0) $display("FAIL reset_outst got %0d exp 0", outst_cnt); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else n_pass++;
    n_total++; if (data_cancel !== 1'b0) $display("FAIL reset_cancel got %b exp 0", data_cancel); else n_pass++;
    resetn = 1'b1;
    #1;
    n_total++; if (icache_req !== 1'b1) $display("FAIL release_icache_req got %b exp 1", icache_req); else n_pass++;
    n_total++; if (icache_addr !== 32'h100) $display("FAIL release_addr got %h exp 00000100", icache_addr); else n_pass++;
    step();
    n_total++; if (outst_cnt !== 2'd1) $display("FAIL release_outst got %0d exp 1", outst_cnt); else n_pass++;
    idle_inputs(); icache_data_ok = 1'b1; icache_rdata = 32'hCAFE0001;
    #1;
    n_total++; if (resp_pc !== 32'h100) $display("FAIL release_resp_pc got %h exp 00000100", resp_pc); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (outst_cnt !== 2'd0) $display("FAIL release_drain got %0d exp 0", outst_cnt); else n_pass++;
  endtask

  task automatic test_issue_full();
    issue(32'hBFC00000);
    issue(32'hBFC00004);
    n_total++; if (outst_cnt !== 2'd2) $display("FAIL full_outst got %0d exp 2", outst_cnt); else n_pass++;
    req_valid = 1'b1; req_pc = 32'hBFC00008; icache_addr_ok = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", req_ready); else n_pass++;
    n_total++; if (icache_req !== 1'b0) $display("FAIL full_req got %b exp 0", icache_req); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (outst_cnt !== 2'd2) $display("FAIL full_hold got %0d exp 2", outst_cnt); else n_pass++;
    icache_data_ok = 1'b1; icache_rdata = 32'h11111111;
    #1;
    n_total++; if (resp_valid !== 1'b1) $display("FAIL ret0_valid got %b exp 1", resp_valid); else n_pass++;
    n_total++; if (resp_pc !== 32'hBFC00000) $display("FAIL ret0_pc got %h exp bfc00000", resp_pc); else n_pass++;
    n_total++; if (resp_inst !== 32'h11111111) $display("FAIL ret0_inst got %h exp 11111111", resp_inst); else n_pass++;
    step();
    icache_rdata = 32'h22222222;
    #1;
    n_total++; if (resp_valid !== 1'b1) $display("FAIL ret1_valid got %b exp 1", resp_valid); else n_pass++;
    n_total++; if (resp_pc !== 32'hBFC00004) $display("FAIL ret1_pc got %h exp bfc00004", resp_pc); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (dut.state_q !== IDLE) $display("FAIL ret_idle got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
  endtask

  task automatic test_flush_drain();
    issue(32'h1000);
    issue(32'h1004);
    flush = 1'b1;
    step();
    idle_inputs();
    n_total++; if (dut.cancel_cnt_q !== 2'd2) $display("FAIL flush_cancel_cnt got %0d exp 2", dut.cancel_cnt_q); else n_pass++;
    n_total++; if (dut.state_q !== DRAIN) $display("FAIL flush_state got %0d exp %0d", dut.state_q, DRAIN); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      icache_data_ok = 1'b1;
      #1;
      n_total++; if (data_cancel !== 1'b1) $display("FAIL drain%0d_cancel got %b exp 1", i, data_cancel); else n_pass++;
      n_total++; if (resp_valid !== 1'b0) $display("FAIL drain%0d_valid got %b exp 0", i, resp_valid); else n_pass++;
      step();
      idle_inputs();
    end
    n_total++; if (dut.state_q !== IDLE) $display("FAIL drain_idle got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
    issue(32'h80000000);
    icache_data_ok = 1'b1;
    #1;
    n_total++; if (resp_valid !== 1'b1) $display("FAIL post_drain_valid got %b exp 1", resp_valid); else n_pass++;
    n_total++; if (resp_pc !== 32'h80000000) $display("FAIL post_drain_pc got %h exp 80000000", resp_pc); else n_pass++;
    step();
    idle_inputs();
  endtask

  task automatic test_flush_with_return();
    issue(32'h2000);
    issue(32'h2004);
    flush = 1'b1; icache_data_ok = 1'b1; req_valid = 1'b1; req_pc = 32'h2008; icache_addr_ok = 1'b1;
    #1;
    n_total++; if (data_cancel !== 1'b1) $display("FAIL fr_cancel got %b exp 1", data_cancel); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL fr_valid got %b exp 0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL fr_ready got %b exp 0", req_ready); else n_pass++;
    n_total++; if (icache_req !== 1'b0) $display("FAIL fr_req got %b exp 0", icache_req); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (dut.cancel_cnt_q !== 2'd1) $display("FAIL fr_cancel_cnt got %0d exp 1", dut.cancel_cnt_q); else n_pass++;
    n_total++; if (outst_cnt !== 2'd1) $display("FAIL fr_outst got %0d exp 1", outst_cnt); else n_pass++;
    icache_data_ok = 1'b1;
    #1;
    n_total++; if (data_cancel !== 1'b1) $display("FAIL fr_second_cancel got %b exp 1", data_cancel); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (outst_cnt !== 2'd0) $display("FAIL fr_end_outst got %0d exp 0", outst_cnt); else n_pass++;
    n_total++; if (dut.state_q !== IDLE) $display("FAIL fr_end_state got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(32'h3000);
    req_valid = 1'b1; req_pc = 32'h3004; icache_addr_ok = 1'b1; icache_data_ok = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready); else n_pass++;
    n_total++; if (resp_pc !== 32'h3000) $display("FAIL b2b_pc0 got %h exp 00003000", resp_pc); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (outst_cnt !== 2'd1) $display("FAIL b2b_outst got %0d exp 1", outst_cnt); else n_pass++;
    n_total++; if (dut.state_q !== BUSY) $display("FAIL b2b_state got %0d exp %0d", dut.state_q, BUSY); else n_pass++;
    icache_data_ok = 1'b1;
    #1;
    n_total++; if (resp_pc !== 32'h3004) $display("FAIL b2b_pc1 got %h exp 00003004", resp_pc); else n_pass++;
    n_total++; if (resp_valid !== 1'b1) $display("FAIL b2b_valid1 got %b exp 1", resp_valid); else n_pass++;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_in_drain();
    issue(32'h4000);
    issue(32'h4004);
    flush = 1'b1; icache_data_ok = 1'b1;
    step();
    idle_inputs();
    n_total++; if (dut.state_q !== DRAIN) $display("FAIL rd_pre_state got %0d exp %0d", dut.state_q, DRAIN); else n_pass++;
`ifdef ICACHE_REQ_PERF_EN
    n_total++; if (perf_req_cnt !== 32'd12) $display("FAIL perf_req got %0d exp 12", perf_req_cnt); else n_pass++;
    n_total++; if (perf_cancel_cnt !== 32'd5) $display("FAIL perf_cancel got %0d exp 5", perf_cancel_cnt); else n_pass++;
    n_total++; if (perf_stall_cnt !== 32'd2) $display("FAIL perf_stall got %0d exp 2", perf_stall_cnt); else n_pass++;
`endif
    resetn = 1'b0;
    step();
    n_total++; if (dut.state_q !== IDLE) $display("FAIL rd_state got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
    n_total++; if (outst_cnt !== 2'd0) $display("FAIL rd_outst got %0d exp 0", outst_cnt); else n_pass++;
    n_total++; if (dut.cancel_cnt_q !== 2'd0) $display("FAIL rd_cancel_cnt got %0d exp 0", dut.cancel_cnt_q); else n_pass++;
`ifdef ICACHE_REQ_PERF_EN
    n_total++; if (perf_req_cnt !== 32'd0) $display("FAIL rd_perf_req got %0d exp 0", perf_req_cnt); else n_pass++;
    n_total++; if (perf_cancel_cnt !== 32'd0) $display("FAIL rd_perf_cancel got %0d exp 0", perf_cancel_cnt); else n_pass++;
    n_total++; if (perf_stall_cnt !== 32'd0) $display("FAIL rd_perf_stall got %0d exp 0", perf_stall_cnt); else n_pass++;
`endif
    resetn = 1'b1;
    step();
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_issue_full();
    test_flush_drain();
    test_flush_with_return();
    test_back_to_back();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
